// File: rtl/adder_error_evaluator_if.sv
// Bundles the evaluator's control/result signals with the adder-facing vector bus.
// master = evaluator side, slave = environment driving start and the adder response.
interface adder_error_evaluator_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 3
);
   logic                  start;
   logic [IN_W-1:0]       dut_in;
   logic [OUT_W-1:0]      dut_out;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [OUT_W-1:0]      max_err;
   logic [IN_W+OUT_W-1:0] sum_err;
   logic [IN_W:0]         err_count;
   logic [IN_W:0]         viol_count;

   modport master (
      input  start, dut_out,
      output dut_in, busy, done, pass, max_err, sum_err, err_count, viol_count
   );

   modport slave (
      output start, dut_out,
      input  dut_in, busy, done, pass, max_err, sum_err, err_count, viol_count
   );
endinterface

// File: rtl/adder_error_evaluator.sv
// Exhaustive sweep of an approximate adder's input space, accumulating error
// statistics against the exact sum and flagging pass when max error <= ET.
module adder_error_evaluator #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 3,
   parameter int ET    = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   adder_error_evaluator_if.master bus
);
   localparam int HALF  = IN_W / 2;
   localparam int SUM_W = IN_W + OUT_W;
   localparam int CNT_W = IN_W + 1;
   localparam logic [OUT_W-1:0] ET_V = ET[OUT_W-1:0];

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [IN_W-1:0]    dut_in_q, dut_in_d;
   logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [OUT_W-1:0]   max_err_q, max_err_d;
   logic [SUM_W-1:0]   sum_err_q, sum_err_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic [CNT_W-1:0]   viol_count_q, viol_count_d;

   logic [OUT_W-1:0]   exact, err, max_nxt;
   logic [OUT_W:0]     diff, diff_neg;

   // Error of the vector currently on dut_in; adder has had a full cycle to settle.
   always_comb begin
      exact    = OUT_W'(dut_in_q[HALF-1:0]) + OUT_W'(dut_in_q[IN_W-1:HALF]);
      diff     = {1'b0, bus.dut_out} - {1'b0, exact};
      diff_neg = -diff;
      err      = diff[OUT_W] ? diff_neg[OUT_W-1:0] : diff[OUT_W-1:0];
      max_nxt  = (err > max_err_q) ? err : max_err_q;
   end

   always_comb begin
      state_d      = state_q;
      dut_in_d     = dut_in_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      pass_d       = pass_q;
      max_err_d    = max_err_q;
      sum_err_d    = sum_err_q;
      err_count_d  = err_count_q;
      viol_count_d = viol_count_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d      = RUN;
               busy_d       = 1'b1;
               dut_in_d     = '0;
               pass_d       = 1'b0;
               max_err_d    = '0;
               sum_err_d    = '0;
               err_count_d  = '0;
               viol_count_d = '0;
            end
         end
         RUN: begin
            max_err_d    = max_nxt;
            sum_err_d    = sum_err_q + {{IN_W{1'b0}}, err};
            err_count_d  = err_count_q + {{IN_W{1'b0}}, (err != '0)};
            viol_count_d = viol_count_q + {{IN_W{1'b0}}, (err > ET_V)};
            if (dut_in_q != '1) begin
               busy_d   = 1'b1;
               dut_in_d = dut_in_q + 1'b1;
            end else begin
               // Last vector: verdict must include its own error.
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (max_nxt <= ET_V);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         dut_in_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         max_err_q    <= '0;
         sum_err_q    <= '0;
         err_count_q  <= '0;
         viol_count_q <= '0;
      end else begin
         state_q      <= state_d;
         dut_in_q     <= dut_in_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         max_err_q    <= max_err_d;
         sum_err_q    <= sum_err_d;
         err_count_q  <= err_count_d;
         viol_count_q <= viol_count_d;
      end
   end

   assign bus.dut_in     = dut_in_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.max_err    = max_err_q;
   assign bus.sum_err    = sum_err_q;
   assign bus.err_count  = err_count_q;
   assign bus.viol_count = viol_count_q;
endmodule

// File: tb/tb_adder_error_evaluator.sv
// Directed bench: behavioural approximate adders in several fault modes, with
// hand-computed sweep results and protocol/reset timing checks.
module tb_adder_error_evaluator;
   logic clk;
   logic rst_n;
   int   mode;
   int   n_chk;
   int   n_err;

   adder_error_evaluator_if #(.IN_W(4), .OUT_W(3)) bus ();

   adder_error_evaluator #(.IN_W(4), .OUT_W(3), .ET(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0 exact, 1 out0 stuck-at-0, 2 out2 stuck-at-0, 3 constant 7
   logic [2:0] exact_s;
   assign exact_s = {1'b0, bus.dut_in[1:0]} + {1'b0, bus.dut_in[3:2]};
   assign bus.dut_out = (mode == 1) ? (exact_s & 3'b110) :
                        (mode == 2) ? (exact_s & 3'b011) :
                        (mode == 3) ? 3'd7 : exact_s;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_dut_in"}, 32'(bus.dut_in), 0);
      chk({tag, "_flags"}, 32'({bus.busy, bus.done, bus.pass}), 0);
      chk({tag, "_max"}, 32'(bus.max_err), 0);
      chk({tag, "_sum"}, 32'(bus.sum_err), 0);
      chk({tag, "_cnts"}, 32'({bus.err_count, bus.viol_count}), 0);
   endtask

   // Start a sweep at the next edge (edge 0); cycle k lies between edge k-1 and k.
   task automatic sweep(input string tag, input int m, input int emax, input int esum,
                        input int ecnt, input int evio, input int epass, input bit repulse);
      int cyc;
      bit seq_ok;
      mode = m;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      cyc = 1;
      seq_ok = 1'b1;
      while (!bus.done && cyc < 40) begin
         if (bus.dut_in !== 4'(cyc - 1) || bus.busy !== 1'b1) seq_ok = 1'b0;
         bus.start = repulse && (cyc == 5);
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      chk({tag, "_done_cycle"}, 32'(cyc), 17);
      chk({tag, "_vec_seq"}, 32'(seq_ok), 1);
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
      chk({tag, "_max_err"}, 32'(bus.max_err), 32'(emax));
      chk({tag, "_sum_err"}, 32'(bus.sum_err), 32'(esum));
      chk({tag, "_err_count"}, 32'(bus.err_count), 32'(ecnt));
      chk({tag, "_viol_count"}, 32'(bus.viol_count), 32'(evio));
      chk({tag, "_pass"}, 32'(bus.pass), 32'(epass));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'({bus.done, bus.busy}), 0);
      chk({tag, "_hold"}, 32'({bus.pass, bus.max_err, bus.sum_err}), 32'({epass[0], emax[2:0], esum[6:0]}));
   endtask

   initial begin
      int cyc;
      n_chk = 0;
      n_err = 0;
      mode = 0;
      bus.start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_zero("reset");
      #22 rst_n = 1'b1;

      sweep("exact", 0, 0, 0, 0, 0, 1, 1'b0);
      sweep("out0_sa0", 1, 1, 8, 8, 0, 1, 1'b0);
      sweep("out2_sa0", 2, 4, 24, 6, 6, 0, 1'b1);
      sweep("const7", 3, 7, 64, 16, 15, 0, 1'b0);

      // Held start: back-to-back sweeps with exactly one IDLE cycle between.
      mode = 0;
      @(negedge clk); bus.start = 1'b1;
      cyc = 0;
      while (!bus.done && cyc < 40) begin @(negedge clk); cyc++; end
      chk("held_done_cycle", 32'(cyc), 17);
      @(negedge clk);
      chk("held_idle_gap", 32'({bus.busy, bus.done}), 0);
      @(negedge clk);
      chk("held_restart", 32'({bus.busy, bus.dut_in}), 32'(5'b10000));
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 40) begin @(negedge clk); cyc++; end
      chk("held_second_done", 32'(bus.done), 1);
      @(negedge clk);

      // Asynchronous reset in cycle 9 of a sweep with nonzero partial results.
      mode = 3;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre_reset_busy", 32'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      @(negedge clk); rst_n = 1'b1;
      sweep("after_rst", 3, 7, 64, 16, 15, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
